// File: rtl/veririsc_pkg.sv
// VeriRISC shared types: ISA opcodes and the 8-phase instruction cycle.
// Imported by the controller, ALU, IR decode and CPU top level.
package veririsc_pkg;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } state_t;

    // Opcodes that read a memory operand and load the accumulator.
    function automatic logic is_aluop(opcode_t op);
        return (op == ADD) || (op == AND) ||
               (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/controller.sv
// VeriRISC instruction-cycle sequencer: 8-phase counter with sticky halt.
// Ports: clk, reset (sync, active-high), opcode, zero in;
//        sel, mem_rd, load_ir, halt, inc_pc, load_ac, load_pc,
//        mem_wr, data_e, phase out (combinational decode of phase).
module controller
    import veririsc_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  opcode_t opcode,
    input  logic    zero,
    output logic    sel,
    output logic    mem_rd,
    output logic    load_ir,
    output logic    halt,
    output logic    inc_pc,
    output logic    load_ac,
    output logic    load_pc,
    output logic    mem_wr,
    output logic    data_e,
    output state_t  phase
);

    state_t r_phase;
    logic   r_halted;
    state_t w_phase_nxt;
    logic   w_halted_nxt;
    logic   w_aluop;

    assign w_aluop = is_aluop(opcode);
    assign phase   = r_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase  <= INST_ADDR;
            r_halted <= 1'b0;
        end else begin
            r_phase  <= w_phase_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    // HLT seen in OP_ADDR freezes the phase there until reset.
    always_comb begin
        w_phase_nxt  = r_phase;
        w_halted_nxt = r_halted;
        if (!r_halted) begin
            if (r_phase == OP_ADDR && opcode == HLT) begin
                w_halted_nxt = 1'b1;
            end else begin
                w_phase_nxt = state_t'(r_phase + 3'd1);
            end
        end
    end

    always_comb begin
        sel     = 1'b0;
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        halt    = 1'b0;
        inc_pc  = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        mem_wr  = 1'b0;
        data_e  = 1'b0;
        if (r_halted) begin
            halt = 1'b1;
        end else begin
            unique case (r_phase)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel    = 1'b1;
                    mem_rd = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel     = 1'b1;
                    mem_rd  = 1'b1;
                    load_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == HLT);
                end
                OP_FETCH: begin
                    mem_rd = w_aluop;
                end
                ALU_OP: begin
                    mem_rd  = w_aluop;
                    load_ac = w_aluop;
                    inc_pc  = (opcode == SKZ) && zero;
                    load_pc = (opcode == JMP);
                    data_e  = (opcode == STO);
                end
                STORE: begin
                    mem_rd  = w_aluop;
                    load_ac = w_aluop;
                    inc_pc  = (opcode == JMP);
                    load_pc = (opcode == JMP);
                    mem_wr  = (opcode == STO);
                    data_e  = (opcode == STO);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for the VeriRISC controller.
// Expected control vectors are queued when stimulus is driven.
module tb_controller;
    import veririsc_pkg::*;

    logic    clk;
    logic    reset;
    opcode_t opcode;
    logic    zero;
    logic    sel, mem_rd, load_ir, halt, inc_pc;
    logic    load_ac, load_pc, mem_wr, data_e;
    state_t  phase;

    int checks;
    int failures;
    int m_ph;
    bit m_h;
    logic [11:0] sb[$];
    logic [11:0] exp_v;

    controller dut (
        .clk    (clk),
        .reset  (reset),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .mem_rd (mem_rd),
        .load_ir(load_ir),
        .halt   (halt),
        .inc_pc (inc_pc),
        .load_ac(load_ac),
        .load_pc(load_pc),
        .mem_wr (mem_wr),
        .data_e (data_e),
        .phase  (phase)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Vector layout: sel,mem_rd,load_ir,halt,inc_pc,load_ac,
    // load_pc,mem_wr,data_e,phase[2:0]
    function automatic logic [11:0] obs();
        return {sel, mem_rd, load_ir, halt, inc_pc, load_ac,
                load_pc, mem_wr, data_e, phase};
    endfunction

    function automatic logic [11:0] model(int ph, int op, bit z, bit h);
        bit alu, e_sel, e_rd, e_ir, e_hlt, e_inc, e_ac, e_pc, e_wr, e_de;
        alu   = (op >= 2) && (op <= 5);
        e_sel = !h && (ph <= 3);
        e_rd  = !h && ((ph >= 1 && ph <= 3) || (ph >= 5 && alu));
        e_ir  = !h && (ph == 2 || ph == 3);
        e_hlt = h || (ph == 4 && op == 0);
        e_inc = !h && (ph == 4 || (ph == 6 && op == 1 && z) ||
                       (ph == 7 && op == 7));
        e_ac  = !h && (ph >= 6) && alu;
        e_pc  = !h && (ph >= 6) && (op == 7);
        e_wr  = !h && (ph == 7) && (op == 6);
        e_de  = !h && (ph >= 6) && (op == 6);
        return {e_sel, e_rd, e_ir, e_hlt, e_inc, e_ac,
                e_pc, e_wr, e_de, 3'(ph)};
    endfunction

    task automatic drive(opcode_t op, bit z);
        @(negedge clk);
        opcode = op;
        zero   = z;
        sb.push_back(model(m_ph, int'(op), z, m_h));
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        if (reset) begin
            m_ph = 0;
            m_h  = 1'b0;
        end else if (!m_h) begin
            if (m_ph == 4 && opcode == HLT) m_h = 1'b1;
            else m_ph = (m_ph + 1) % 8;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_ph  = 0;
        m_h   = 1'b0;
        sb.push_back(model(0, int'(opcode), zero, 1'b0));
        exp_v = sb.pop_front();
        checks++;
        if (obs() !== exp_v) begin
            failures++;
            $display("FAIL reset got=%h exp=%h", obs(), exp_v);
        end
    endtask

    task automatic test_add();
        for (int c = 0; c < 9; c++) begin
            drive(ADD, 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if (obs() !== exp_v) begin
                failures++;
                $display("FAIL add c=%0d got=%h exp=%h", c, obs(), exp_v);
            end
            advance();
        end
    endtask

    task automatic test_sto();
        for (int c = 0; c < 8; c++) begin
            drive(STO, 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if (obs() !== exp_v) begin
                failures++;
                $display("FAIL sto c=%0d got=%h exp=%h", c, obs(), exp_v);
            end
            advance();
        end
    endtask

    task automatic test_jmp();
        for (int c = 0; c < 8; c++) begin
            drive(JMP, 1'b1);
            exp_v = sb.pop_front();
            checks++;
            if (obs() !== exp_v) begin
                failures++;
                $display("FAIL jmp c=%0d got=%h exp=%h", c, obs(), exp_v);
            end
            advance();
        end
    endtask

    task automatic test_skz();
        for (int c = 0; c < 16; c++) begin
            drive(SKZ, (c < 8));
            exp_v = sb.pop_front();
            checks++;
            if (obs() !== exp_v) begin
                failures++;
                $display("FAIL skz c=%0d got=%h exp=%h", c, obs(), exp_v);
            end
            advance();
        end
    endtask

    task automatic test_hlt();
        test_reset();
        for (int c = 0; c < 15; c++) begin
            drive((c < 5) ? HLT : ADD, 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if (obs() !== exp_v) begin
                failures++;
                $display("FAIL hlt c=%0d got=%h exp=%h", c, obs(), exp_v);
            end
            advance();
        end
        checks++;
        if (phase !== OP_ADDR || halt !== 1'b1 || inc_pc !== 1'b0) begin
            failures++;
            $display("FAIL hlt_hold got ph=%0d halt=%b inc=%b exp ph=4 halt=1 inc=0",
                     phase, halt, inc_pc);
        end
        test_reset();
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 7; c++) begin
            drive(LDA, 1'b0);
            exp_v = sb.pop_front();
            checks++;
            if (obs() !== exp_v) begin
                failures++;
                $display("FAIL lda c=%0d got=%h exp=%h", c, obs(), exp_v);
            end
            if (c < 6) advance();
        end
        reset = 1'b1;
        #1;
        checks++;
        if (phase !== state_t'(3'(m_ph)) || load_ac !== 1'b1) begin
            failures++;
            $display("FAIL sync_reset got ph=%0d ac=%b exp ph=%0d ac=1",
                     phase, load_ac, m_ph);
        end
        advance();
        #1;
        reset = 1'b0;
        sb.push_back(model(m_ph, int'(opcode), zero, m_h));
        exp_v = sb.pop_front();
        checks++;
        if (obs() !== exp_v || m_ph != 0) begin
            failures++;
            $display("FAIL mid_reset got=%h exp=%h", obs(), exp_v);
        end
    endtask

    task automatic test_back_to_back();
        opcode_t op;
        for (int c = 0; c < 48; c++) begin
            op = opcode_t'($urandom_range(7, (c < 40) ? 1 : 0));
            drive(op, 1'($urandom_range(1, 0)));
            exp_v = sb.pop_front();
            checks++;
            if (obs() !== exp_v || (mem_rd && mem_wr)) begin
                failures++;
                $display("FAIL b2b c=%0d got=%h exp=%h", c, obs(), exp_v);
            end
            advance();
        end
        test_reset();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_ph     = 0;
        m_h      = 1'b0;
        reset    = 1'b1;
        opcode   = ADD;
        zero     = 1'b0;
        test_reset();
        test_add();
        test_reset();
        test_sto();
        test_jmp();
        test_skz();
        test_hlt();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
